// File: rtl/lsu_queued.sv
// Queued load/store unit: in-order request FIFO feeding a single-outstanding memory sequencer.
// Optional misalignment fault on dispatch is enabled with `define LSU_ALIGN_CHECK_EN.
module lsu_queued #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int QDEPTH = 4,
  parameter int TAG_W  = 6,
  parameter int OFF_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_W-1:0]        req_base,
  input  logic signed [OFF_W-1:0]  req_off,
  input  logic [DATA_W-1:0]        req_wdata0,
  input  logic [DATA_W-1:0]        req_wdata1,
  input  logic [TAG_W-1:0]         req_tag0,
  input  logic [TAG_W-1:0]         req_tag1,
  output logic                     mem_ren,
  output logic [ADDR_W-1:0]        mem_raddr,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_wready,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_store,
  output logic                     wb_fault,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRIDE = DATA_W / 8;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [TAG_W-1:0]  tag0;
    logic [TAG_W-1:0]  tag1;
  } entry_t;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, WB} state_t;

  function automatic logic [ADDR_W-1:0] eff_addr(input logic [ADDR_W-1:0] base,
                                                 input logic signed [OFF_W-1:0] off);
    return base + {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  entry_t             fifo_q [QDEPTH];
  entry_t             enq_p0;
  entry_t             head;
  entry_t             cur_p1;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               empty;
  logic               head_misal;
  logic               cur_fault;
  state_t             state_q;
  state_t             state_n;
  logic               rd_done;
  logic               wb_vld_p2;
  logic [TAG_W-1:0]   wb_tag_p2;
  logic [DATA_W-1:0]  wb_data_p2;

  // Stage p0: address generation at enqueue, FIFO write
  always_comb begin
    enq_p0        = '0;
    enq_p0.op     = req_op;
    enq_p0.addr0  = eff_addr(req_base, req_off);
    enq_p0.addr1  = enq_p0.addr0 + ADDR_W'(STRIDE);
    enq_p0.wdata0 = req_wdata0;
    enq_p0.wdata1 = req_wdata1;
    enq_p0.tag0   = req_tag0;
    enq_p0.tag1   = req_tag1;
  end

  // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
  assign req_ready = (count != CNT_W'(QDEPTH));
  assign empty     = (count == '0);
  assign push      = req_valid & req_ready;
  assign head      = fifo_q[rd_ptr];

`ifdef LSU_ALIGN_CHECK_EN
  localparam int AL_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  assign head_misal = |head.addr0[AL_W-1:0];
`else
  assign head_misal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= enq_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Stage p1: dispatched op held for the duration of its memory accesses
  always_ff @(posedge clk) begin
    if (pop) cur_p1 <= head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_fault <= 1'b0;
    end else begin
      state_q <= state_n;
      if (pop) cur_fault <= head_misal;
    end
  end

  always_comb begin
    state_n = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        if (head_misal)      state_n = WB;
        else if (head.op[0]) state_n = WR0;
        else                 state_n = RD0;
      end
      RD0:     if (mem_rvalid) state_n = cur_p1.op[1] ? RD1 : IDLE;
      RD1:     if (mem_rvalid) state_n = IDLE;
      WR0:     if (mem_wready) state_n = cur_p1.op[1] ? WR1 : WB;
      WR1:     if (mem_wready) state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_raddr = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      RD0: begin mem_ren = 1'b1; mem_raddr = cur_p1.addr0; end
      RD1: begin mem_ren = 1'b1; mem_raddr = cur_p1.addr1; end
      WR0: begin mem_wen = 1'b1; mem_waddr = cur_p1.addr0; mem_wdata = cur_p1.wdata0; end
      WR1: begin mem_wen = 1'b1; mem_waddr = cur_p1.addr1; mem_wdata = cur_p1.wdata1; end
      default: ;
    endcase
  end

  // Stage p2: load data captured on the read handshake, presented the following cycle
  assign rd_done = mem_ren & mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_vld_p2 <= 1'b0;
    else        wb_vld_p2 <= rd_done;
  end

  always_ff @(posedge clk) begin
    if (rd_done) begin
      wb_tag_p2  <= (state_q == RD1) ? cur_p1.tag1 : cur_p1.tag0;
      wb_data_p2 <= mem_rdata;
    end
  end

  // Load writebacks and WB-state completions can never coincide: an IDLE cycle always separates them.
  always_comb begin
    wb_valid = wb_vld_p2;
    wb_tag   = wb_vld_p2 ? wb_tag_p2 : '0;
    wb_data  = wb_vld_p2 ? wb_data_p2 : '0;
    wb_store = 1'b0;
    wb_fault = 1'b0;
    if (state_q == WB) begin
      wb_valid = 1'b1;
      wb_tag   = cur_p1.tag0;
      wb_data  = '0;
      wb_store = cur_p1.op[0];
      wb_fault = cur_fault;
    end
  end

  assign busy = !empty || (state_q != IDLE);

endmodule
